// File: rtl/frogger_life_manager.sv
// -----------------------------------------------------------------------------
// frogger_life_manager
//
// Game-rule stage that sits after the collision detector. Each cycle it looks
// at the frog row plus the car-hit / on-log flags and decides whether the frog
// dies (car hit or drowning), reaches the goal, or keeps playing. It keeps the
// life count and score, sequences the death animation, the respawn pulse and
// the post-respawn grace window, and flags game-over / win.
//
// Ports
//   i_Clk        system clock
//   i_Rst_L      synchronous reset, active low, overrides every other input
//   i_Start      start / restart request (level)
//   i_Tick       one-cycle game-tick strobe (frame rate)
//   i_Frogger_Y  current frog row
//   i_Collided   frog overlaps a car
//   i_On_Log     frog stands on a log tile
//   o_State      IDLE=0 PLAY=1 DYING=2 RESPAWN=3 GAME_OVER=4 WIN=5
//   o_Lives      lives remaining
//   o_Score      goals reached this game
//   o_Respawn    one-cycle pulse, frog controller reloads the origin position
//   o_Dying      high throughout DYING
//   o_Game_Over  high in GAME_OVER
//   o_Win        high in WIN
//
// Every output is a register; the effect of an input shows up the cycle after.
// -----------------------------------------------------------------------------
module frogger_life_manager #(
    parameter int c_LIVES       = 3,
    parameter int c_WATER_Y_MIN = 1,
    parameter int c_WATER_Y_MAX = 5,
    parameter int c_GOAL_Y      = 0,
    parameter int c_DEATH_TICKS = 30,
    parameter int c_GRACE_TICKS = 4,
    parameter int c_WIN_SCORE   = 5
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Start,
    input  logic       i_Tick,
    input  logic [5:0] i_Frogger_Y,
    input  logic       i_Collided,
    input  logic       i_On_Log,
    output logic [2:0] o_State,
    output logic [1:0] o_Lives,
    output logic [7:0] o_Score,
    output logic       o_Respawn,
    output logic       o_Dying,
    output logic       o_Game_Over,
    output logic       o_Win
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_DYING     = 3'd2,
        ST_RESPAWN   = 3'd3,
        ST_GAME_OVER = 3'd4,
        ST_WIN       = 3'd5
    } state_t;

    localparam logic [1:0] LIVES_INIT  = 2'(c_LIVES);
    localparam logic [5:0] WATER_Y_MIN = 6'(c_WATER_Y_MIN);
    localparam logic [5:0] WATER_Y_MAX = 6'(c_WATER_Y_MAX);
    localparam logic [5:0] GOAL_Y      = 6'(c_GOAL_Y);
    localparam logic [7:0] DEATH_TICKS = 8'(c_DEATH_TICKS);
    localparam logic [7:0] GRACE_TICKS = 8'(c_GRACE_TICKS);
    localparam logic [7:0] WIN_SCORE   = 8'(c_WIN_SCORE);

    state_t     state_reg, state_next;
    logic [1:0] lives_reg, lives_next;
    logic [7:0] score_reg, score_next;
    logic [7:0] death_cnt_reg, death_cnt_next;
    logic [7:0] grace_cnt_reg, grace_cnt_next;
    logic       respawn_reg, respawn_next;
    logic       dying_reg, dying_next;
    logic       game_over_reg, game_over_next;
    logic       win_reg, win_next;

    // Hazard / goal decode of the current frog position.
    logic       in_water;
    logic       hazard;
    logic       goal;
    logic       grace_active;
    logic       death_done;
    logic [7:0] score_inc;
    logic [1:0] lives_dec;

    assign in_water     = (i_Frogger_Y >= WATER_Y_MIN) && (i_Frogger_Y <= WATER_Y_MAX);
    assign hazard       = i_Collided || (in_water && !i_On_Log);
    assign goal         = (i_Frogger_Y == GOAL_Y);
    assign grace_active = (grace_cnt_reg != 8'd0);
    // The tick that takes the death counter from 1 to 0 ends the animation.
    // A zero count (never loaded that way) is also treated as finished so
    // the FSM cannot get stuck in DYING.
    assign death_done   = i_Tick && (death_cnt_reg <= 8'd1);
    assign score_inc    = (score_reg == 8'hFF) ? 8'hFF : score_reg + 8'd1;
    assign lives_dec    = (lives_reg == 2'd0) ? 2'd0 : lives_reg - 2'd1;

    // -------------------------------------------------------------------------
    // State register (plus the datapath registers that travel with it)
    // -------------------------------------------------------------------------
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_reg     <= ST_IDLE;
            lives_reg     <= LIVES_INIT;
            score_reg     <= 8'd0;
            death_cnt_reg <= 8'd0;
            grace_cnt_reg <= 8'd0;
            respawn_reg   <= 1'b0;
            dying_reg     <= 1'b0;
            game_over_reg <= 1'b0;
            win_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            lives_reg     <= lives_next;
            score_reg     <= score_next;
            death_cnt_reg <= death_cnt_next;
            grace_cnt_reg <= grace_cnt_next;
            respawn_reg   <= respawn_next;
            dying_reg     <= dying_next;
            game_over_reg <= game_over_next;
            win_reg       <= win_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (i_Start) state_next = ST_RESPAWN;
            end
            ST_RESPAWN: begin
                state_next = ST_PLAY;
            end
            ST_PLAY: begin
                // Inside the grace window the frog is invulnerable and the
                // goal is not scored either. Hazard beats goal.
                if (!grace_active) begin
                    if (hazard) begin
                        state_next = ST_DYING;
                    end else if (goal) begin
                        state_next = (score_inc == WIN_SCORE) ? ST_WIN : ST_RESPAWN;
                    end
                end
            end
            ST_DYING: begin
                if (death_done) begin
                    state_next = (lives_reg == 2'd0) ? ST_GAME_OVER : ST_RESPAWN;
                end
            end
            ST_GAME_OVER, ST_WIN: begin
                if (i_Start) state_next = ST_RESPAWN;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output / datapath logic. Flags are decoded from the next state so the
    // registered flag lines up with the registered state.
    // -------------------------------------------------------------------------
    always_comb begin
        lives_next     = lives_reg;
        score_next     = score_reg;
        death_cnt_next = death_cnt_reg;
        grace_cnt_next = grace_cnt_reg;
        respawn_next   = (state_next == ST_RESPAWN);
        dying_next     = (state_next == ST_DYING);
        game_over_next = (state_next == ST_GAME_OVER);
        win_next       = (state_next == ST_WIN);

        case (state_reg)
            ST_IDLE, ST_GAME_OVER, ST_WIN: begin
                if (i_Start) begin
                    lives_next = LIVES_INIT;
                    score_next = 8'd0;
                end
            end
            ST_RESPAWN: begin
                grace_cnt_next = GRACE_TICKS;
            end
            ST_PLAY: begin
                if (grace_active) begin
                    if (i_Tick) grace_cnt_next = grace_cnt_reg - 8'd1;
                end else if (hazard) begin
                    // Counter is loaded, not decremented, even when a tick
                    // lands on this same cycle.
                    lives_next     = lives_dec;
                    death_cnt_next = DEATH_TICKS;
                end else if (goal) begin
                    score_next = score_inc;
                end
            end
            ST_DYING: begin
                if (i_Tick && (death_cnt_reg != 8'd0)) begin
                    death_cnt_next = death_cnt_reg - 8'd1;
                end
            end
            default: begin
            end
        endcase
    end

    assign o_State     = state_reg;
    assign o_Lives     = lives_reg;
    assign o_Score     = score_reg;
    assign o_Respawn   = respawn_reg;
    assign o_Dying     = dying_reg;
    assign o_Game_Over = game_over_reg;
    assign o_Win       = win_reg;

endmodule

// File: tb/tb_frogger_life_manager.sv
// -----------------------------------------------------------------------------
// tb_frogger_life_manager
//
// Directed scenarios plus a randomized run. A behavioural game model (plain
// integers, updated once per clock from the game rules) tracks the expected
// state, lives and score; directed scenarios check against hand-derived
// constants, the randomized run checks every cycle against the model.
// Inputs are driven on the falling edge, outputs sampled on the falling edge
// after the active edge.
// -----------------------------------------------------------------------------
module tb_frogger_life_manager;

    localparam int L = 3;
    localparam int D = 30;
    localparam int G = 4;
    localparam int W = 5;

    localparam int S_IDLE = 0, S_PLAY = 1, S_DYING = 2, S_RESPAWN = 3,
                   S_GAME_OVER = 4, S_WIN = 5;

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic       start_s = 1'b0;
    logic       tick_s = 1'b0;
    logic [5:0] y_s = 6'd6;
    logic       coll_s = 1'b0;
    logic       log_s = 1'b0;

    logic [2:0] o_state;
    logic [1:0] o_lives;
    logic [7:0] o_score;
    logic       o_respawn, o_dying, o_game_over, o_win;

    int checks = 0;
    int errors = 0;

    // Reference game model
    int m_state = S_IDLE;
    int m_lives = L;
    int m_score = 0;
    int m_death = 0;
    int m_grace = 0;

    always #5 clk = ~clk;

    frogger_life_manager dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_l),
        .i_Start     (start_s),
        .i_Tick      (tick_s),
        .i_Frogger_Y (y_s),
        .i_Collided  (coll_s),
        .i_On_Log    (log_s),
        .o_State     (o_state),
        .o_Lives     (o_lives),
        .o_Score     (o_score),
        .o_Respawn   (o_respawn),
        .o_Dying     (o_dying),
        .o_Game_Over (o_game_over),
        .o_Win       (o_win)
    );

    // One clock of the game rules, applied to the model.
    task automatic model_update(input bit rst, input bit start, input bit tick,
                                input int y, input bit coll, input bit onlog);
        bit hazard;
        bit goal;
        hazard = coll || ((y >= 1) && (y <= 5) && !onlog);
        goal   = (y == 0);
        if (!rst) begin
            m_state = S_IDLE; m_lives = L; m_score = 0; m_death = 0; m_grace = 0;
        end else if (m_state == S_IDLE || m_state == S_GAME_OVER || m_state == S_WIN) begin
            if (start) begin
                m_lives = L; m_score = 0; m_state = S_RESPAWN;
            end
        end else if (m_state == S_RESPAWN) begin
            m_grace = G;
            m_state = S_PLAY;
        end else if (m_state == S_PLAY) begin
            if (m_grace > 0) begin
                if (tick) m_grace--;
            end else if (hazard) begin
                m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                m_death = D;
                m_state = S_DYING;
            end else if (goal) begin
                m_score = (m_score < 255) ? m_score + 1 : 255;
                m_state = (m_score == W) ? S_WIN : S_RESPAWN;
            end
        end else if (m_state == S_DYING) begin
            if (tick) begin
                m_death--;
                if (m_death == 0) m_state = (m_lives == 0) ? S_GAME_OVER : S_RESPAWN;
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model across the clock edge and
    // return on the following falling edge, ready for sampling.
    task automatic step(input bit rst, input bit start, input bit tick,
                        input int y, input bit coll, input bit onlog);
        rst_l = rst; start_s = start; tick_s = tick;
        y_s = 6'(y); coll_s = coll; log_s = onlog;
        @(posedge clk);
        model_update(rst, start, tick, y, coll, onlog);
        @(negedge clk);
        $display("t=%0t rst_l=%b start=%b tick=%b y=%0d coll=%b log=%b -> state=%0d lives=%0d score=%0d rsp=%b dy=%b go=%b win=%b",
                 $time, rst, start, tick, y, coll, onlog, o_state, o_lives, o_score,
                 o_respawn, o_dying, o_game_over, o_win);
    endtask

    // Stimulus-only helpers (no comparisons inside).
    task automatic expire_grace();
        for (int i = 0; i < G; i++) step(1, 0, 1, 6, 0, 0);
    endtask

    task automatic begin_game();
        step(0, 0, 0, 6, 0, 0);
        step(1, 1, 0, 6, 0, 0);   // -> RESPAWN
        step(1, 0, 0, 6, 0, 0);   // -> PLAY, grace loaded
        expire_grace();
    endtask

    task automatic test_reset();
        step(0, 1, 1, 0, 1, 0);
        step(0, 1, 1, 0, 1, 0);
        checks++;
        if (o_state !== 3'd0 || o_lives !== 2'd3 || o_score !== 8'd0 ||
            o_respawn !== 1'b0 || o_dying !== 1'b0 || o_game_over !== 1'b0 || o_win !== 1'b0) begin
            errors++;
            $display("FAIL reset: state=%0d lives=%0d score=%0d flags=%b%b%b%b required 0/3/0/0000",
                     o_state, o_lives, o_score, o_respawn, o_dying, o_game_over, o_win);
        end
    endtask

    task automatic test_car_death();
        int dying_cycles;
        int respawn_pulses;
        begin_game();
        // Tick coincides with the hit: counter must still load the full 30.
        step(1, 0, 1, 6, 1, 0);
        checks++;
        if (o_state !== 3'd2 || o_lives !== 2'd2 || o_dying !== 1'b1) begin
            errors++;
            $display("FAIL car_hit: state=%0d lives=%0d dying=%b required 2/2/1", o_state, o_lives, o_dying);
        end
        dying_cycles = 1;
        respawn_pulses = 0;
        for (int i = 0; i < D; i++) begin
            step(1, 0, 1, 6, 1, 0);
            if (o_dying === 1'b1) dying_cycles++;
            if (o_respawn === 1'b1) respawn_pulses++;
        end
        checks++;
        if (dying_cycles != D || o_state !== 3'd3 || respawn_pulses != 1) begin
            errors++;
            $display("FAIL death_len: dying_cycles=%0d state=%0d pulses=%0d required %0d/3/1",
                     dying_cycles, o_state, respawn_pulses, D);
        end
        step(1, 0, 1, 6, 1, 0);
        checks++;
        if (o_state !== 3'd1 || o_respawn !== 1'b0 || o_lives !== 2'd2) begin
            errors++;
            $display("FAIL post_respawn: state=%0d respawn=%b lives=%0d required 1/0/2", o_state, o_respawn, o_lives);
        end
    endtask

    task automatic test_drown();
        begin_game();
        step(1, 0, 0, 3, 0, 1);
        checks++;
        if (o_state !== 3'd1 || o_lives !== 2'd3) begin
            errors++;
            $display("FAIL on_log: state=%0d lives=%0d required 1/3", o_state, o_lives);
        end
        step(1, 0, 0, 6, 0, 0);
        checks++;
        if (o_state !== 3'd1 || o_lives !== 2'd3) begin
            errors++;
            $display("FAIL dry_row6: state=%0d lives=%0d required 1/3", o_state, o_lives);
        end
        step(1, 0, 0, 3, 0, 0);
        checks++;
        if (o_state !== 3'd2 || o_lives !== 2'd2) begin
            errors++;
            $display("FAIL drown_row3: state=%0d lives=%0d required 2/2", o_state, o_lives);
        end
        for (int i = 0; i < D; i++) step(1, 0, 1, 3, 0, 0);
        step(1, 0, 0, 6, 0, 0);
        expire_grace();
        step(1, 0, 0, 5, 0, 0);
        checks++;
        if (o_state !== 3'd2 || o_lives !== 2'd1) begin
            errors++;
            $display("FAIL drown_row5: state=%0d lives=%0d required 2/1", o_state, o_lives);
        end
    endtask

    task automatic test_game_over();
        begin_game();
        for (int d = 0; d < 3; d++) begin
            step(1, 0, 0, 6, 1, 0);
            for (int i = 0; i < D; i++) step(1, 0, 1, 6, 0, 0);
            if (d < 2) begin
                step(1, 0, 0, 6, 0, 0);
                expire_grace();
            end
        end
        checks++;
        if (o_state !== 3'd4 || o_game_over !== 1'b1 || o_lives !== 2'd0 || o_dying !== 1'b0) begin
            errors++;
            $display("FAIL game_over: state=%0d go=%b lives=%0d dying=%b required 4/1/0/0",
                     o_state, o_game_over, o_lives, o_dying);
        end
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 1, 0);
        checks++;
        if (o_state !== 3'd4 || o_lives !== 2'd0 || o_game_over !== 1'b1) begin
            errors++;
            $display("FAIL go_hold: state=%0d lives=%0d go=%b required 4/0/1", o_state, o_lives, o_game_over);
        end
        step(1, 1, 0, 6, 0, 0);
        checks++;
        if (o_state !== 3'd3 || o_lives !== 2'd3 || o_score !== 8'd0 ||
            o_respawn !== 1'b1 || o_game_over !== 1'b0) begin
            errors++;
            $display("FAIL go_restart: state=%0d lives=%0d score=%0d respawn=%b go=%b required 3/3/0/1/0",
                     o_state, o_lives, o_score, o_respawn, o_game_over);
        end
    endtask

    task automatic test_win();
        begin_game();
        for (int k = 1; k <= W; k++) begin
            step(1, 0, 0, 0, 0, 0);
            checks++;
            if (o_score !== 8'(k) || o_lives !== 2'd3) begin
                errors++;
                $display("FAIL goal_score: goal=%0d score=%0d lives=%0d required %0d/3", k, o_score, o_lives, k);
            end
            if (k < W) begin
                checks++;
                if (o_state !== 3'd3 || o_respawn !== 1'b1) begin
                    errors++;
                    $display("FAIL goal_respawn: goal=%0d state=%0d respawn=%b required 3/1", k, o_state, o_respawn);
                end
                step(1, 0, 0, 6, 0, 0);
                expire_grace();
            end
        end
        checks++;
        if (o_state !== 3'd5 || o_win !== 1'b1) begin
            errors++;
            $display("FAIL win: state=%0d win=%b required 5/1", o_state, o_win);
        end
        // Restart, then a car hit on the goal row: hazard wins over goal.
        step(1, 1, 0, 6, 0, 0);
        step(1, 0, 0, 6, 0, 0);
        expire_grace();
        step(1, 0, 0, 0, 1, 0);
        checks++;
        if (o_state !== 3'd2 || o_score !== 8'd0 || o_lives !== 2'd2) begin
            errors++;
            $display("FAIL hit_on_goal: state=%0d score=%0d lives=%0d required 2/0/2", o_state, o_score, o_lives);
        end
    endtask

    task automatic test_grace_and_reset();
        step(0, 0, 0, 6, 0, 0);
        step(1, 1, 0, 6, 0, 0);
        step(1, 0, 0, 6, 0, 0);   // PLAY, grace = 4
        step(1, 0, 1, 6, 1, 0);   // grace 3, hit ignored
        step(1, 0, 0, 0, 0, 0);   // goal ignored
        step(1, 0, 1, 3, 0, 0);   // grace 2, drown ignored
        checks++;
        if (o_state !== 3'd1 || o_lives !== 2'd3 || o_score !== 8'd0) begin
            errors++;
            $display("FAIL grace_ignore: state=%0d lives=%0d score=%0d required 1/3/0", o_state, o_lives, o_score);
        end
        step(1, 0, 1, 6, 0, 0);
        step(1, 0, 1, 6, 1, 0);   // grace 1 -> 0 this cycle, hit still ignored
        checks++;
        if (o_state !== 3'd1) begin
            errors++;
            $display("FAIL grace_last_tick: state=%0d required 1", o_state);
        end
        step(1, 0, 0, 6, 1, 0);
        checks++;
        if (o_state !== 3'd2 || o_lives !== 2'd2) begin
            errors++;
            $display("FAIL grace_over_hit: state=%0d lives=%0d required 2/2", o_state, o_lives);
        end
        for (int i = 0; i < 5; i++) step(1, 0, 1, 6, 0, 0);
        step(0, 0, 1, 6, 0, 0);
        checks++;
        if (o_state !== 3'd0 || o_lives !== 2'd3 || o_dying !== 1'b0 || o_score !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_dying: state=%0d lives=%0d dying=%b score=%0d required 0/3/0/0",
                     o_state, o_lives, o_dying, o_score);
        end
    endtask

    task automatic test_random();
        bit r, s, t, c, lg;
        int y;
        step(0, 0, 0, 6, 0, 0);
        for (int n = 0; n < 1500; n++) begin
            r  = ($urandom_range(0, 199) != 0);
            s  = ($urandom_range(0, 7) == 0);
            t  = ($urandom_range(0, 2) == 0);
            y  = int'($urandom_range(0, 7));
            c  = ($urandom_range(0, 5) == 0);
            lg = ($urandom_range(0, 3) != 0);
            step(r, s, t, y, c, lg);
            checks++;
            if (o_state !== 3'(m_state) || o_lives !== 2'(m_lives) || o_score !== 8'(m_score) ||
                o_respawn !== (m_state == S_RESPAWN) || o_dying !== (m_state == S_DYING) ||
                o_game_over !== (m_state == S_GAME_OVER) || o_win !== (m_state == S_WIN)) begin
                errors++;
                $display("FAIL random[%0d]: state=%0d lives=%0d score=%0d flags=%b%b%b%b required %0d/%0d/%0d",
                         n, o_state, o_lives, o_score, o_respawn, o_dying, o_game_over, o_win,
                         m_state, m_lives, m_score);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_car_death();
        test_drown();
        test_game_over();
        test_win();
        test_grace_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
